// File: rtl/adder_sweep_checker_if.sv
// Operand/result bus between the sweep checker (master) and the adder under test (slave).
interface adder_sweep_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             cin_out;
  logic [WIDTH-1:0] s_in;
  logic             cout_in;

  modport master (output a_out, b_out, cin_out, input s_in, cout_in);
  modport slave  (input a_out, b_out, cin_out, output s_in, cout_in);
endinterface

// File: rtl/adder_sweep_checker.sv
// Exhaustive {cin,b,a} sweep of a W-bit adder: drive, wait SETTLE_CYCLES, compare against
// the arithmetic sum, count mismatches and capture the first failing vector.
module adder_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  adder_sweep_checker_if.master dut,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*WIDTH+1:0]    err_count,
  output logic                  fail_valid,
  output logic [2*WIDTH:0]      fail_vec,
  output logic [WIDTH:0]        fail_obs
);
  localparam int VW  = 2*WIDTH + 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic [SCW-1:0]     settle_q, settle_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d;
  logic               pass_q, pass_d;
  logic [VW:0]        err_q, err_d;
  logic               fv_q, fv_d;
  logic [VW-1:0]      fvec_q, fvec_d;
  logic [WIDTH:0]     fobs_q, fobs_d;
  logic [WIDTH:0]     exp_sum, obs;
  logic               mismatch;

  // The driven operands are exactly the vector under test, so the reference uses them.
  assign exp_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign obs      = {dut.cout_in, dut.s_in};
  assign mismatch = (obs != exp_sum);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;
    fobs_d   = fobs_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          fobs_d  = '0;
          pass_d  = 1'b0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        a_d      = vec_q[WIDTH-1:0];
        b_d      = vec_q[2*WIDTH-1:WIDTH];
        cin_d    = vec_q[2*WIDTH];
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = CHECK;
        else                         settle_d = settle_q + 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
            fobs_d = obs;
          end
        end
        if (vec_q == '1) begin
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fvec_q   <= '0;
      fobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fvec_q   <= fvec_d;
      fobs_q   <= fobs_d;
    end
  end

  assign dut.a_out   = a_q;
  assign dut.b_out   = b_q;
  assign dut.cin_out = cin_q;
  assign busy        = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_valid  = fv_q;
  assign fail_vec    = fvec_q;
  assign fail_obs    = fobs_q;
endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench: a default checker against a faultable combinational adder, and a
// SETTLE_CYCLES=1 checker against an adder with one output register stage.
module tb_adder_sweep_checker;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int   mode = 0;

  logic          busy, done, pass, fail_valid;
  logic [2*W+1:0] err_count;
  logic [2*W:0]  fail_vec;
  logic [W:0]    fail_obs;
  logic          busy1, done1, pass1, fail_valid1;
  logic [2*W+1:0] err_count1;
  logic [2*W:0]  fail_vec1;
  logic [W:0]    fail_obs1;

  int n_cmp = 0;
  int n_fail = 0;

  adder_sweep_checker_if #(.WIDTH(W)) bus0 ();
  adder_sweep_checker_if #(.WIDTH(W)) bus1 ();

  adder_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut(bus0.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_obs(fail_obs));

  adder_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .fail_vec(fail_vec1), .fail_obs(fail_obs1));

  always #5 clk = ~clk;

  // Adder under test: mode 1 sticks s[0] at 0, mode 2 sticks cout at 0.
  always_comb begin
    {bus0.cout_in, bus0.s_in} = {1'b0, bus0.a_out} + {1'b0, bus0.b_out} + {{W{1'b0}}, bus0.cin_out};
    if (mode == 1) bus0.s_in[0] = 1'b0;
    if (mode == 2) bus0.cout_in = 1'b0;
  end

  always_ff @(posedge clk)
    {bus1.cout_in, bus1.s_in} <= {1'b0, bus1.a_out} + {1'b0, bus1.b_out} + {{W{1'b0}}, bus1.cin_out};

  typedef struct {
    int          mode;
    int          err;
    logic        fvalid;
    logic [8:0]  fvec;
    logic [4:0]  fobs;
    logic        pass;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start1 = 1'b0;
  endtask

  // Counts edges until done; optionally pulses start for one edge after pulse_at edges.
  task automatic wait_done(input bit sel, input int pulse_at, output int cycles);
    cycles = 0;
    forever begin
      @(posedge clk);
      cycles++;
      #1;
      start = 1'b0;
      if ((sel ? done1 : done) === 1'b1) break;
      if (cycles > 5000) begin
        chk("done_timeout", 32'(cycles), 32'd0);
        break;
      end
      if (!sel && cycles == pulse_at) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic chk_results(input string tag, input vec_t v);
    chk({tag, "_done"},       32'(done),       32'd1);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_err_count"},  32'(err_count),  32'(v.err));
    chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(v.fvalid));
    chk({tag, "_fail_vec"},   32'(fail_vec),   32'(v.fvec));
    chk({tag, "_fail_obs"},   32'(fail_obs),   32'(v.fobs));
    chk({tag, "_pass"},       32'(pass),       32'(v.pass));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_pass"},  32'(pass),  32'd0);
    chk({tag, "_err"},   32'(err_count), 32'd0);
    chk({tag, "_fv"},    32'(fail_valid), 32'd0);
    chk({tag, "_fvec"},  32'(fail_vec),  32'd0);
    chk({tag, "_fobs"},  32'(fail_obs),  32'd0);
    chk({tag, "_ops"},   32'({bus0.cin_out, bus0.b_out, bus0.a_out}), 32'd0);
  endtask

  initial begin
    vec_t tbl[3];
    int cyc;
    tbl[0] = '{mode: 0, err: 0,   fvalid: 1'b0, fvec: 9'd0,   fobs: 5'd0, pass: 1'b1};
    tbl[1] = '{mode: 1, err: 256, fvalid: 1'b1, fvec: 9'd1,   fobs: 5'd0, pass: 1'b0};
    tbl[2] = '{mode: 2, err: 256, fvalid: 1'b1, fvec: 9'h01F, fobs: 5'd0, pass: 1'b0};

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      pulse_start(1'b0);
      chk($sformatf("m%0d_busy_after_start", i), 32'(busy), 32'd1);
      wait_done(1'b0, -1, cyc);
      chk($sformatf("m%0d_cycles", i), 32'(cyc), 32'd2048);
      chk_results($sformatf("m%0d", i), tbl[i]);
      chk($sformatf("m%0d_ops_hold", i), 32'({bus0.cin_out, bus0.b_out, bus0.a_out}), 32'h1FF);
    end

    // Registered adder with a one-cycle settle: 512 * 3 edges.
    pulse_start(1'b1);
    wait_done(1'b1, -1, cyc);
    chk("reg1_cycles", 32'(cyc), 32'd1536);
    chk("reg1_pass", 32'(pass1), 32'd1);
    chk("reg1_err", 32'(err_count1), 32'd0);
    chk("reg1_fv", 32'(fail_valid1), 32'd0);

    // start mid-sweep is ignored.
    mode = 0;
    pulse_start(1'b0);
    wait_done(1'b0, 500, cyc);
    chk("midstart_cycles", 32'(cyc), 32'd2048);
    chk_results("midstart", tbl[0]);

    // start in DONE relaunches; done drops on the next edge.
    pulse_start(1'b0);
    chk("restart_done_low", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done(1'b0, -1, cyc);
    chk("restart_cycles", 32'(cyc), 32'd2048);
    chk_results("restart", tbl[0]);

    // Asynchronous reset mid-cycle during a sweep with errors accumulating.
    mode = 1;
    pulse_start(1'b0);
    repeat (700) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    pulse_start(1'b0);
    wait_done(1'b0, -1, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd2048);
    chk_results("post_rst", tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_sweep_checker.md
Name: adder_sweep_checker

Overview:
- Self-checking stimulus/response engine for the W-bit ripple adder netlists produced by the BLIF flow.
- Drives every {CIN, B, A} vector into the adder under test and samples its {COUT, S} after a settle interval.
- Compares each sample against the arithmetic sum, counts mismatches and records the first failing vector.
- Sits beside the adder netlist in hardware builds, replacing manual stimulus.

Parameters:
- WIDTH, 4, operand width W of A, B and S.
- SETTLE_CYCLES, 2, cycles waited after driving a vector before sampling; legal range is 1 or more.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sampled in IDLE or DONE only; launches a full sweep.
- a_out  output  WIDTH  registered operand A to the adder under test.
- b_out  output  WIDTH  registered operand B to the adder under test.
- cin_out  output  1  registered carry-in to the adder under test.
- s_in  input  WIDTH  sum returned by the adder under test.
- cout_in  input  1  carry-out returned by the adder under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep end until the next start or reset.
- pass  output  1  valid while done is high; 1 when err_count==0.
- err_count  output  2*WIDTH+2  number of mismatching vectors.
- fail_valid  output  1  high once a first failure has been captured.
- fail_vec  output  2*WIDTH+1  {cin,b,a} index of the first failing vector.
- fail_obs  output  WIDTH+1  observed {cout_in,s_in} at the first failure.

Behaviour:
- Reset (asynchronous, any state): all outputs, counters and capture registers go to 0; state goes to IDLE.
- Vector counter vec has N = 2^(2W+1) values. Mapping: a = vec[W-1:0], b = vec[2W-1:W], cin = vec[2W].
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - clear vec, err_count, fail_valid, fail_vec, fail_obs, done and pass;
  - set busy=1;
  - go to DRIVE.
- DRIVE:
  - load a_out, b_out and cin_out from vec;
  - clear the settle counter;
  - go to SETTLE.
- SETTLE: increment the settle counter; when it reaches SETTLE_CYCLES-1, go to CHECK.
- CHECK: compare {cout_in,s_in} against a+b+cin, computed at W+1 bits with zero extension.
  - On mismatch: err_count += 1. err_count cannot overflow because N fits in 2W+2 bits.
  - On mismatch with fail_valid=0: capture fail_vec=vec and fail_obs={cout_in,s_in}, then set fail_valid=1.
  - If vec == N-1: go to DONE, busy=0, done=1, pass=(final err_count==0), with this vector's mismatch included.
  - Otherwise: vec += 1 and go to DRIVE.
- Timing:
  - each vector takes SETTLE_CYCLES+2 cycles;
  - done rises N*(SETTLE_CYCLES+2) edges after the edge that samples start;
  - with defaults, N=512 and done rises after 2048 edges.
- start while busy=1 is ignored.
- start held high continuously restarts a sweep immediately after every DONE.
- Operand outputs hold the last vector in DONE. They return to 0 only on reset.
- A combinational DUT, or a DUT with up to SETTLE_CYCLES registered stages of output latency, must pass.

Test Plan:
- Ideal combinational adder model, defaults, start pulse: busy high for 2048 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- s_in[0] forced to 0: err_count=256, fail_valid=1, fail_vec=9'd1, fail_obs=5'b00000, pass=0.
- cout_in forced to 0: err_count=256, fail_vec=9'h01F (a=15, b=1, cin=0), fail_obs=5'b00000, pass=0.
- SETTLE_CYCLES=1 with the adder followed by one register stage: done after 1536 edges, pass=1, err_count=0.
- start pulsed mid-sweep at cycle 500: no effect, and done still arrives at 2048. start pulsed in DONE: done drops next cycle and a new 2048-cycle sweep runs.
- rst asserted asynchronously mid-cycle at cycle ~700: all outputs immediately 0, state IDLE. A new start then gives a full sweep with results identical to scenario 1.
